// File: rtl/lsq_param_queue_pkg.sv
// Shared types and default sizing for the parametrised load/store queue.
// Default geometry is an 8-entry queue with doubleword-granular hazard matching.
package lsq_param_queue_pkg;

  localparam int LSQ_DEPTH     = 8;
  localparam int LSQ_ADDR_W    = 64;
  localparam int LSQ_DATA_W    = 64;
  localparam int LSQ_CTRL_W    = 17;
  localparam int LSQ_MATCH_LSB = 3;

  typedef logic [$clog2(LSQ_DEPTH)-1:0] lsq_id_t;

  typedef struct packed {
    logic [LSQ_ADDR_W-1:0] addr;
    logic [LSQ_DATA_W-1:0] data;
    logic [LSQ_CTRL_W-1:0] ctrl;
    logic                  store;
  } lsq_entry_t;

  function automatic bit lsq_is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/lsq_param_queue_if.sv
// Handshake bundle between the exe-stage producer, the queue and the dcache-side consumer.
// The slave modport is the queue itself; the master modport is whoever drives it.
interface lsq_param_queue_if
  import lsq_param_queue_pkg::*;
#(
  parameter int DEPTH  = LSQ_DEPTH,
  parameter int ADDR_W = LSQ_ADDR_W,
  parameter int DATA_W = LSQ_DATA_W,
  parameter int CTRL_W = LSQ_CTRL_W
);
  localparam int ID_W  = $clog2(DEPTH);
  localparam int CNT_W = ID_W + 1;

  logic              flush_i;
  logic              push_valid_i;
  logic              push_ready_o;
  logic [ADDR_W-1:0] push_addr_i;
  logic [DATA_W-1:0] push_data_i;
  logic [CTRL_W-1:0] push_ctrl_i;
  logic              push_store_i;
  logic [ID_W-1:0]   push_id_o;
  logic              pop_valid_o;
  logic              pop_ready_i;
  logic [ADDR_W-1:0] pop_addr_o;
  logic [DATA_W-1:0] pop_data_o;
  logic [CTRL_W-1:0] pop_ctrl_o;
  logic              pop_store_o;
  logic [ADDR_W-1:0] query_addr_i;
  logic              query_hit_o;
  logic [CNT_W-1:0]  count_o;
  logic              full_o;
  logic              empty_o;

  modport master (
    output flush_i, push_valid_i, push_addr_i, push_data_i, push_ctrl_i, push_store_i,
           pop_ready_i, query_addr_i,
    input  push_ready_o, push_id_o, pop_valid_o, pop_addr_o, pop_data_o, pop_ctrl_o,
           pop_store_o, query_hit_o, count_o, full_o, empty_o
  );

  modport slave (
    input  flush_i, push_valid_i, push_addr_i, push_data_i, push_ctrl_i, push_store_i,
           pop_ready_i, query_addr_i,
    output push_ready_o, push_id_o, pop_valid_o, pop_addr_o, pop_data_o, pop_ctrl_o,
           pop_store_o, query_hit_o, count_o, full_o, empty_o
  );

endinterface

// File: rtl/lsq_param_queue_addr_match.sv
// Older-store hazard detector: compares every occupied store entry against a lookup address.
// Address bits below MATCH_LSB are masked so any byte inside the same granule hits.
module lsq_param_queue_addr_match #(
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 64,
  parameter int MATCH_LSB = 3
) (
  input  logic [DEPTH-1:0]             valid_i,
  input  logic [DEPTH-1:0]             store_i,
  input  logic [DEPTH-1:0][ADDR_W-1:0] addr_i,
  input  logic [ADDR_W-1:0]            query_addr_i,
  output logic                         hit_o
);

  localparam logic [ADDR_W-1:0] MATCH_MASK = {ADDR_W{1'b1}} << MATCH_LSB;

  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_i[i] && store_i[i] && (((addr_i[i] ^ query_addr_i) & MATCH_MASK) == '0)) begin
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lsq_param_queue.sv
// Circular load/store queue with valid/ready on both sides, first-word-fall-through head,
// occupancy count and a combinational older-store address-match query.
module lsq_param_queue
  import lsq_param_queue_pkg::*;
#(
  parameter int DEPTH     = LSQ_DEPTH,
  parameter int DATA_W    = LSQ_DATA_W,
  parameter int ADDR_W    = LSQ_ADDR_W,
  parameter int CTRL_W    = LSQ_CTRL_W,
  parameter int MATCH_LSB = LSQ_MATCH_LSB
) (
  input  logic              clk_i,
  input  logic              rst_i,
  lsq_param_queue_if.slave  bus
);

  localparam int ID_W  = $clog2(DEPTH);
  localparam int CNT_W = ID_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  if (!lsq_is_pow2(DEPTH)) begin : g_bad_depth
    $fatal(1, "lsq_param_queue: DEPTH must be a power of two >= 2");
  end

  logic [ID_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d, store_q, store_d;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [DEPTH-1:0][CTRL_W-1:0] ctrl_q, ctrl_d;

  logic full_w, empty_w, push_ready_w, pop_valid_w, push_w, pop_w;

  // Ready/valid come from registered count only; flush blanks both for its cycle.
  assign full_w       = (count_q == DEPTH_C);
  assign empty_w      = (count_q == '0);
  assign push_ready_w = ~full_w & ~bus.flush_i;
  assign pop_valid_w  = ~empty_w & ~bus.flush_i;
  assign push_w       = bus.push_valid_i & push_ready_w;
  assign pop_w        = pop_valid_w & bus.pop_ready_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    store_d = store_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (bus.flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
    end else begin
      if (push_w) begin
        valid_d[tail_q] = 1'b1;
        store_d[tail_q] = bus.push_store_i;
        addr_d[tail_q]  = bus.push_addr_i;
        data_d[tail_q]  = bus.push_data_i;
        ctrl_d[tail_q]  = bus.push_ctrl_i;
        tail_d          = tail_q + 1'b1;
      end
      if (pop_w) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push_w) - CNT_W'(pop_w);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      store_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      store_q <= store_d;
    end
  end

  // Payload storage carries no reset; the valid bits alone say what is live.
  always_ff @(posedge clk_i) begin
    addr_q <= addr_d;
    data_q <= data_d;
    ctrl_q <= ctrl_d;
  end

  lsq_param_queue_addr_match #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .MATCH_LSB (MATCH_LSB)
  ) u_addr_match (
    .valid_i      (valid_q),
    .store_i      (store_q),
    .addr_i       (addr_q),
    .query_addr_i (bus.query_addr_i),
    .hit_o        (bus.query_hit_o)
  );

  assign bus.push_ready_o = push_ready_w;
  assign bus.push_id_o    = tail_q;
  assign bus.pop_valid_o  = pop_valid_w;
  assign bus.pop_addr_o   = empty_w ? '0 : addr_q[head_q];
  assign bus.pop_data_o   = empty_w ? '0 : data_q[head_q];
  assign bus.pop_ctrl_o   = empty_w ? '0 : ctrl_q[head_q];
  assign bus.pop_store_o  = empty_w ? 1'b0 : store_q[head_q];
  assign bus.count_o      = count_q;
  assign bus.full_o       = full_w;
  assign bus.empty_o      = empty_w;

  a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i) count_q <= DEPTH_C);
  a_push_masked: assert property (@(posedge clk_i) disable iff (rst_i) push_w |-> push_ready_w);

endmodule

// File: tb/tb_lsq_param_queue.sv
// Directed bench for lsq_param_queue: stimulus pushes expected entries into a scoreboard,
// a negedge monitor pops and compares whenever the queue hands over its head.
module tb_lsq_param_queue;
  import lsq_param_queue_pkg::*;

  localparam int DEPTH = LSQ_DEPTH;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  lsq_param_queue_if #(.DEPTH(DEPTH), .ADDR_W(LSQ_ADDR_W), .DATA_W(LSQ_DATA_W), .CTRL_W(LSQ_CTRL_W)) bus ();

  lsq_param_queue #(
    .DEPTH(DEPTH), .DATA_W(LSQ_DATA_W), .ADDR_W(LSQ_ADDR_W),
    .CTRL_W(LSQ_CTRL_W), .MATCH_LSB(LSQ_MATCH_LSB)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int         tests_run    = 0;
  int         tests_failed = 0;
  lsq_entry_t exp_q[$];
  int         mcount;
  lsq_id_t    mtail;
  bit         mon_en = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic setIdle();
    bus.push_valid_i = 1'b0;
    bus.push_addr_i  = '0;
    bus.push_data_i  = '0;
    bus.push_ctrl_i  = '0;
    bus.push_store_i = 1'b0;
    bus.pop_ready_i  = 1'b0;
    bus.flush_i      = 1'b0;
  endtask

  // One clock of stimulus; the model decides acceptance from its own count.
  task automatic applyStimulus(input bit push, input logic [63:0] addr, input logic [63:0] data,
                               input logic [16:0] ctrl, input bit store, input bit pop, input bit flush);
    bit acc, pp;
    bus.push_valid_i = push;
    bus.push_addr_i  = addr;
    bus.push_data_i  = data;
    bus.push_ctrl_i  = ctrl;
    bus.push_store_i = store;
    bus.pop_ready_i  = pop;
    bus.flush_i      = flush;
    acc = push && !flush && (mcount < DEPTH);
    pp  = pop && !flush && (mcount > 0);
    @(posedge clk_i);
    if (flush) begin
      exp_q.delete();
      mcount = 0;
      mtail  = '0;
    end else begin
      if (acc) begin
        exp_q.push_back('{addr: addr, data: data, ctrl: ctrl, store: store});
        mtail = mtail + 1'b1;
      end
      mcount = mcount + int'(acc) - int'(pp);
    end
    #1;
    setIdle();
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, '0, '0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2 && mcount > 0; i++) applyStimulus(0, '0, '0, '0, 0, 1, 0);
  endtask

  task automatic checkQuery(input string name, input logic [63:0] qaddr, input bit exp_hit);
    bus.query_addr_i = qaddr;
    #1;
    checkOutput(name, 64'(bus.query_hit_o), 64'(exp_hit));
  endtask

  task automatic checkStatus(input string tag);
    checkOutput({tag, "_count"},      64'(bus.count_o),      64'(mcount));
    checkOutput({tag, "_empty"},      64'(bus.empty_o),      64'(mcount == 0));
    checkOutput({tag, "_full"},       64'(bus.full_o),       64'(mcount == DEPTH));
    checkOutput({tag, "_push_ready"}, 64'(bus.push_ready_o), 64'(mcount != DEPTH));
    checkOutput({tag, "_push_id"},    64'(bus.push_id_o),    64'(mtail));
  endtask

  // Monitor: handshake observed at negedge commits at the next posedge.
  always @(negedge clk_i) begin : monitor
    lsq_entry_t e;
    if (mon_en && !rst_i) begin
      checkOutput("pop_valid", 64'(bus.pop_valid_o), 64'(mcount != 0 && !bus.flush_i));
      if (bus.pop_valid_o && bus.pop_ready_i) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL pop_underflow: got a pop with addr 0x%0h, expected no entry", bus.pop_addr_o);
        end else begin
          e = exp_q.pop_front();
          checkOutput("pop_addr",  bus.pop_addr_o,         e.addr);
          checkOutput("pop_data",  bus.pop_data_o,         e.data);
          checkOutput("pop_ctrl",  64'(bus.pop_ctrl_o),    64'(e.ctrl));
          checkOutput("pop_store", 64'(bus.pop_store_o),   64'(e.store));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    setIdle();
    bus.query_addr_i = '0;
    mcount = 0;
    mtail  = '0;
    rst_i  = 1'b1;
    #3;
    checkOutput("rst_pop_valid", 64'(bus.pop_valid_o), 64'(0));
    checkOutput("rst_query_hit", 64'(bus.query_hit_o), 64'(0));
    checkStatus("rst");
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #2;
    mon_en = 1'b1;
    idleCycles(2);
    checkStatus("idle");

    // Fill to full, then an extra push must be ignored.
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1, 64'h100 + 64'(8 * i), 64'hA000 + 64'(i), 17'(i), 0, 0, 0);
    checkStatus("full");
    checkOutput("full_count8", 64'(bus.count_o), 64'(8));
    applyStimulus(1, 64'h999, 64'h9, 17'h9, 0, 0, 0);
    checkStatus("ninth_push");

    // Full: push+pop only pops; then push+pop holds count.
    applyStimulus(1, 64'h200, 64'hB000, 17'h1F, 0, 1, 0);
    checkStatus("full_pushpop");
    checkOutput("full_pushpop_count7", 64'(bus.count_o), 64'(7));
    applyStimulus(1, 64'h208, 64'hB001, 17'h1E, 0, 1, 0);
    checkStatus("pushpop");
    drain();
    checkStatus("drained1");

    // Fall-through latency and stability under back-pressure.
    applyStimulus(1, 64'h40, 64'hDEAD, 17'h3, 0, 0, 0);
    checkOutput("ftl_valid", 64'(bus.pop_valid_o), 64'(1));
    checkOutput("ftl_data",  bus.pop_data_o, 64'hDEAD);
    for (int i = 0; i < 3; i++) begin
      idleCycles(1);
      checkOutput("hold_data", bus.pop_data_o, 64'hDEAD);
      checkOutput("hold_addr", bus.pop_addr_o, 64'h40);
    end
    drain();
    checkOutput("empty_pop_data", bus.pop_data_o, 64'h0);

    // Hazard query.
    applyStimulus(1, 64'h1008, 64'h5, 17'h5, 1, 0, 0);
    applyStimulus(1, 64'h2008, 64'h6, 17'h6, 0, 0, 0);
    checkQuery("hit_same_dword", 64'h100F, 1);
    checkQuery("hit_next_dword", 64'h1010, 0);
    checkQuery("hit_load_entry", 64'h2008, 0);
    bus.query_addr_i = 64'h3000;
    fork
      applyStimulus(1, 64'h3000, 64'h7, 17'h7, 1, 0, 0);
      begin
        #1;
        checkOutput("hit_same_cycle_push", 64'(bus.query_hit_o), 64'(0));
      end
    join
    checkQuery("hit_after_push", 64'h3000, 1);
    applyStimulus(0, '0, '0, '0, 0, 1, 0);
    checkQuery("hit_after_pop", 64'h1008, 0);
    checkQuery("hit_other_store", 64'h3004, 1);
    drain();

    // Flush beats a concurrent push.
    for (int i = 0; i < 5; i++)
      applyStimulus(1, 64'h400 + 64'(8 * i), 64'hC000 + 64'(i), 17'(i), 1, 0, 0);
    checkStatus("five");
    fork
      applyStimulus(1, 64'h777, 64'h777, 17'h7, 1, 1, 1);
      begin
        #1;
        checkOutput("flush_push_ready", 64'(bus.push_ready_o), 64'(0));
        checkOutput("flush_pop_valid",  64'(bus.pop_valid_o),  64'(0));
      end
    join
    checkStatus("flushed");
    checkQuery("hit_after_flush", 64'h400, 0);
    applyStimulus(1, 64'h500, 64'h55, 17'h2, 0, 0, 0);
    checkStatus("post_flush");
    drain();

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 64'h600 + 64'(8 * i), 64'hD000 + 64'(i), 17'(i), 1, 0, 0);
    #1;
    rst_i = 1'b1;
    exp_q.delete();
    mcount = 0;
    mtail  = '0;
    #1;
    checkOutput("async_rst_pop_valid", 64'(bus.pop_valid_o), 64'(0));
    checkOutput("async_rst_hit",       64'(bus.query_hit_o), 64'(0));
    checkStatus("async_rst");
    @(negedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #2;
    idleCycles(2);
    checkStatus("after_rst");
    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
